// File: rtl/sram_dp_be.sv
`default_nettype none
// ============================================================================
//  Module   : sram_dp_be
//  Purpose  : True dual-port synchronous line memory with per-byte write
//             enables, a read-valid handshake, selectable same-port
//             read-during-write behaviour, deterministic write-write
//             collision resolution (port A wins per byte) and a post-reset
//             clearing sequence that zeroes every line before use.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             a_req/a_we/a_be     - port A request, write flag, byte enables
//             a_addr/a_wdata      - port A line address and write data
//             a_rdata/a_rvalid    - port A returned line and its valid flag
//             b_*                 - identical set for port B
//             init_done           - high once the clear sequence has finished
//             collision           - pulse: both ports wrote the same line
//  Options  : SRAM_DP_OUT_REG_EN  - adds an output register stage on
//             rdata/rvalid/collision of both ports (latency 2 instead of 1).
//  Revision : 1.0 - initial release
// ============================================================================
module sram_dp_be #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 10,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_rvalid,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid,
  output logic                    init_done,
  output logic                    collision
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;

  // Storage array; not reset, the clear sequence zeroes it instead.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    a_acc, b_acc, a_wr, b_wr, same_addr, wr_coll;
  logic [DATA_WIDTH-1:0]   a_old, b_old, a_line, b_line, a_ret, b_ret;

  logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                    a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic                    collision_q, collision_d;

  // --------------------------------------------------------------------------
  // Request qualification: requests are only honoured in READY.
  // --------------------------------------------------------------------------
  always_comb begin
    a_acc     = !rst && (state_q == ST_READY) && a_req;
    b_acc     = !rst && (state_q == ST_READY) && b_req;
    a_wr      = a_acc && a_we;
    b_wr      = b_acc && b_we;
    same_addr = (a_addr == b_addr);
    wr_coll   = a_wr && b_wr && same_addr;
  end

  // Asynchronous lookup of the pre-write lines.
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  // --------------------------------------------------------------------------
  // Post-write line images. Each starts from the old line, overlays B's
  // enabled bytes, then A's enabled bytes, so A wins on any shared byte.
  // The other port's bytes are only overlaid when it writes the same line.
  // --------------------------------------------------------------------------
  always_comb begin
    a_line = a_old;
    b_line = b_old;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (b_wr && same_addr && b_be[i]) a_line[i*8 +: 8] = b_wdata[i*8 +: 8];
      if (a_wr && a_be[i])              a_line[i*8 +: 8] = a_wdata[i*8 +: 8];
      if (b_wr && b_be[i])              b_line[i*8 +: 8] = b_wdata[i*8 +: 8];
      if (a_wr && same_addr && a_be[i]) b_line[i*8 +: 8] = a_wdata[i*8 +: 8];
    end
  end

  // --------------------------------------------------------------------------
  // Returned data. A read-only access always sees the old line, even when the
  // other port writes the same address; only the writing port itself may see
  // the merged line, and only in write-first mode.
  // --------------------------------------------------------------------------
  generate
    if (RDW_MODE == 0) begin : g_write_first
      assign a_ret = a_wr ? a_line : a_old;
      assign b_ret = b_wr ? b_line : b_old;
    end else begin : g_read_first
      assign a_ret = a_old;
      assign b_ret = b_old;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Clear-sequence FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_INIT: begin
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // First output stage
  // --------------------------------------------------------------------------
  always_comb begin
    a_rvalid_d  = a_acc;
    b_rvalid_d  = b_acc;
    a_rdata_d   = a_acc ? a_ret : a_rdata_q;
    b_rdata_d   = b_acc ? b_ret : b_rdata_q;
    collision_d = wr_coll;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_ptr_q   <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      collision_q <= collision_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage writes. On a same-line collision port A's image already carries
  // B's bytes, so B's write is suppressed to keep a single writer.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_INIT) begin
      mem[clr_ptr_q] <= '0;
    end else begin
      if (a_wr)             mem[a_addr] <= a_line;
      if (b_wr && !wr_coll) mem[b_addr] <= b_line;
    end
  end

  assign init_done = (state_q == ST_READY);

`ifdef SRAM_DP_OUT_REG_EN
  // Second output stage; it simply delays the first, so rdata keeps holding.
  logic [DATA_WIDTH-1:0] a_rdata_s2_q, a_rdata_s2_d, b_rdata_s2_q, b_rdata_s2_d;
  logic                  a_rvalid_s2_q, a_rvalid_s2_d, b_rvalid_s2_q, b_rvalid_s2_d;
  logic                  collision_s2_q, collision_s2_d;

  always_comb begin
    a_rdata_s2_d   = a_rdata_q;
    b_rdata_s2_d   = b_rdata_q;
    a_rvalid_s2_d  = a_rvalid_q;
    b_rvalid_s2_d  = b_rvalid_q;
    collision_s2_d = collision_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_s2_q   <= '0;
      b_rdata_s2_q   <= '0;
      a_rvalid_s2_q  <= 1'b0;
      b_rvalid_s2_q  <= 1'b0;
      collision_s2_q <= 1'b0;
    end else begin
      a_rdata_s2_q   <= a_rdata_s2_d;
      b_rdata_s2_q   <= b_rdata_s2_d;
      a_rvalid_s2_q  <= a_rvalid_s2_d;
      b_rvalid_s2_q  <= b_rvalid_s2_d;
      collision_s2_q <= collision_s2_d;
    end
  end

  assign a_rdata   = a_rdata_s2_q;
  assign b_rdata   = b_rdata_s2_q;
  assign a_rvalid  = a_rvalid_s2_q;
  assign b_rvalid  = b_rvalid_s2_q;
  assign collision = collision_s2_q;
`else
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign collision = collision_q;
`endif

endmodule
`default_nettype wire

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- True dual-port synchronous line memory; successor to the 512-bit line SRAM.
- Adds parametrised width, per-byte write enables, read-valid handshake, selectable same-port read-during-write mode, and defined write-write collision resolution.
- Adds a post-reset clearing state machine, so no location reads as X after initialisation.
- Sits under the cache/line-buffer controllers; both ports are owned by independent requesters.

Parameters:
- DATA_WIDTH, 512, line width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, line address bits; depth = 2**ADDR_WIDTH lines.
- RDW_MODE, 0, same-port read-during-write: 0 = write-first (new data), 1 = read-first (old data).

Ports:
- clk  in  1  clock; all activity on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request.
- a_we  in  1  port A write (1) / read-only (0).
- a_be  in  DATA_WIDTH/8  port A byte enables; bit i covers bits [8i+7:8i].
- a_addr  in  ADDR_WIDTH  port A line address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_rdata  out  DATA_WIDTH  port A read data.
- a_rvalid  out  1  port A read data valid.
- b_req, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid: identical for port B.
- init_done  out  1  high once the memory clear has completed.
- collision  out  1  one-cycle pulse: both ports wrote the same address.

Behaviour:
- Reset (rst=1 at posedge): a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, collision=0, init_done=0.
  - The FSM enters INIT with clear pointer 0.
  - Reset asserted mid-INIT restarts the clear from address 0.
- FSM states:
  - INIT: each cycle write all-zero to ram[ptr], ptr++. When ptr = 2**ADDR_WIDTH-1 is written, go to READY. init_done rises the cycle after the last clear write, so INIT lasts exactly 2**ADDR_WIDTH cycles.
  - READY: normal operation. Stays in READY until rst.
- During INIT all a_req/b_req are ignored: no write, rvalid stays 0. Requesters must wait for init_done.
- Every accepted request (req=1 in READY) returns rdata with rvalid=1 exactly 1 cycle later. This includes writes, which return the word per RDW_MODE.
- rvalid is 0 in any cycle not following an accepted request. rdata holds its last value when rvalid=0.
- Write: only bytes with be[i]=1 are updated. we=1 with be=0 performs no update but still returns read data.
- Same-port read-during-write:
  - RDW_MODE=0: returns the merged new line.
  - RDW_MODE=1: returns the pre-write line.
- Cross-port, same address, one port writes and the other reads: the reader gets the pre-write (old) line, regardless of RDW_MODE.
- Both ports write the same address in one cycle:
  - Bytes enabled on A take a_wdata (A wins).
  - Bytes enabled only on B take b_wdata.
  - collision=1 in the following cycle, even if the be masks do not overlap.
  - Each port's own returned data follows RDW_MODE, using the final merged line when RDW_MODE=0.
- Both ports read the same address: no conflict, both get identical data.
- Address range is full; there is no out-of-range case.

Optional Feature:
- Macro SRAM_DP_OUT_REG_EN.
- When defined: an extra output register stage on rdata/rvalid of both ports. Read latency becomes 2 cycles; collision is also delayed to 2 cycles. Back-to-back requests still pipeline at 1 per cycle. Reset clears both stages.
- When undefined: latency is 1 cycle as above.

Test Plan:
- Init: assert rst 2 cycles, release → init_done=0 for exactly 1024 cycles, then 1. Then read addr 0, 511, 1023 → rdata=0, rvalid=1 one cycle after each req.
- Reset mid-init: rst after 300 INIT cycles → init_done first rises 1024 cycles after the rst release. Requests issued during INIT give rvalid=0 and no write.
- Byte enables: write addr 5 with all-ones data, be=all ones; then write 0x00… with be[0]=1 only; read → byte 0 = 0x00, all other bytes 0xFF.
- RDW: A writes 0xAA… to addr 7 (previously 0x55…) → RDW_MODE=0 returns 0xAA…, RDW_MODE=1 returns 0x55…. The same cycle, B reads addr 7 → 0x55….
- Collision: A writes 0x11… with be=lower half, B writes 0x22… with be=all ones, same addr → collision=1 next cycle. Stored line: lower half 0x11, upper half 0x22.
- Throughput: interleaved reads every cycle on both ports for 64 cycles → 64 rvalid pulses per port, in order, with correct data. With SRAM_DP_OUT_REG_EN, the same results appear shifted by 1 cycle.
